mem_bus_arbiter: RTL and testbench

- Shares the single tagged memory bus between the LSQ (data loads/stores) and the instruction fetch unit (icache misses).
- Each cycle it picks one requester, drives the bus command, and records which requester owns each accepted load tag.
- Returned data is steered to the owning requester by tag.
- Fetch tags outstanding at a fetch flush are marked stale, and their data is dropped on return.

---
 rtl/mem_bus_arbiter_pkg.sv | 24 ++
 rtl/mem_bus_arbiter_if.sv | 17 +
 rtl/mem_bus_arbiter_tag_table.sv | 60 ++++++
 rtl/mem_bus_arbiter.sv | 102 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings and sizing for the memory bus arbiter and its tag table.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'b00,
    BUS_LOAD  = 2'b01,
    BUS_STORE = 2'b10
  } bus_cmd_e;

  localparam int NUM_MEM_TAGS     = 15;
  localparam int MEM_TAG_W        = 4;
  localparam int DEF_STARVE_LIMIT = 4;
  localparam int DEF_CNT_W        = 3;

  localparam logic OWNER_LSQ = 1'b0;
  localparam logic OWNER_IF  = 1'b1;

  typedef struct packed {
    logic valid;
    logic owner;
    logic stale;
  } tag_entry_t;

endpackage

// File: rtl/mem_bus_arbiter_if.sv
// Tagged memory bus: command channel out, accept tag and read-data return in.
interface mem_bus_arbiter_if #(
  parameter int TAG_W = mem_bus_arbiter_pkg::MEM_TAG_W
);
  import mem_bus_arbiter_pkg::*;

  bus_cmd_e           command;
  logic [63:0]        addr;
  logic [63:0]        wdata;
  logic [TAG_W-1:0]   response;
  logic [63:0]        data;
  logic [TAG_W-1:0]   tag;

  modport master (output command, addr, wdata, input response, data, tag);
  modport slave  (input command, addr, wdata, output response, data, tag);

endinterface

// File: rtl/mem_bus_arbiter_tag_table.sv
// Owner table for outstanding load tags plus a running count of valid entries.
module mem_tag_table
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS = NUM_MEM_TAGS,
  parameter int TAG_W    = MEM_TAG_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             set_en,
  input  logic [TAG_W-1:0] set_tag,
  input  logic             set_owner,
  input  logic             set_stale,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] clr_tag,
  input  logic             flush_en,
  input  logic [TAG_W-1:0] lookup_tag,
  output tag_entry_t       lookup_entry,
  output logic [TAG_W-1:0] count
);

  tag_entry_t       entries_q [1:NUM_TAGS];
  tag_entry_t       entries_d [1:NUM_TAGS];
  logic [TAG_W-1:0] count_q, count_d;

  always_comb begin
    lookup_entry = '0;
    for (int i = 1; i <= NUM_TAGS; i++) begin
      if (lookup_tag == TAG_W'(i)) lookup_entry = entries_q[i];
    end
  end

  // Set is applied last so a tag reissued on the cycle it returns stays live.
  always_comb begin
    for (int i = 1; i <= NUM_TAGS; i++) begin
      entries_d[i] = entries_q[i];
      if (flush_en && entries_q[i].valid && entries_q[i].owner == OWNER_IF) begin
        entries_d[i].stale = 1'b1;
      end
      if (clr_en && clr_tag == TAG_W'(i)) entries_d[i] = '0;
      if (set_en && set_tag == TAG_W'(i)) begin
        entries_d[i] = '{valid: 1'b1, owner: set_owner, stale: set_stale};
      end
    end
    count_d = count_q + TAG_W'(set_en) - TAG_W'(clr_en);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 1; i <= NUM_TAGS; i++) entries_q[i] <= '0;
      count_q <= '0;
    end else begin
      for (int i = 1; i <= NUM_TAGS; i++) entries_q[i] <= entries_d[i];
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares the tagged memory bus between the LSQ and instruction fetch and
// steers returned data back to whichever requester owns the tag.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int NUM_TAGS     = NUM_MEM_TAGS,
  parameter int TAG_W        = MEM_TAG_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        lsq_req,
  input  logic [63:0]       lsq_addr,
  input  logic [63:0]       lsq_data,
  input  logic              if_req,
  input  logic [63:0]       if_addr,
  input  logic              if_flush,
  mem_bus_arbiter_if.master mem,
  output logic              lsq_grant,
  output logic [TAG_W-1:0]  lsq_grant_tag,
  output logic              lsq_rvalid,
  output logic [TAG_W-1:0]  lsq_rtag,
  output logic [63:0]       lsq_rdata,
  output logic              if_grant,
  output logic [TAG_W-1:0]  if_grant_tag,
  output logic              if_rvalid,
  output logic [TAG_W-1:0]  if_rtag,
  output logic [63:0]       if_rdata,
  output logic [TAG_W-1:0]  outstanding
);

  logic             full, lsq_load, lsq_ok, if_ok, if_first, lsq_win, if_win;
  logic             set_en, set_owner, set_stale, ret_hit, deliver;
  logic [CNT_W-1:0] starve_q, starve_d;
  tag_entry_t       ret_entry;

  mem_tag_table #(.NUM_TAGS(NUM_TAGS), .TAG_W(TAG_W)) u_table (
    .clk          (clk),
    .reset        (reset),
    .set_en       (set_en),
    .set_tag      (mem.response),
    .set_owner    (set_owner),
    .set_stale    (set_stale),
    .clr_en       (ret_hit),
    .clr_tag      (mem.tag),
    .flush_en     (if_flush),
    .lookup_tag   (mem.tag),
    .lookup_entry (ret_entry),
    .count        (outstanding)
  );

  // Everything is qualified by reset so outputs drop to zero as soon as it asserts.
  always_comb begin
    full     = (outstanding == TAG_W'(NUM_TAGS));
    lsq_load = (lsq_req == BUS_LOAD);
    lsq_ok   = reset && ((lsq_req == BUS_STORE) || (lsq_load && !full));
    if_ok    = reset && if_req && !full;
    if_first = (starve_q == CNT_W'(STARVE_LIMIT));
    if_win   = if_ok && (if_first || !lsq_ok);
    lsq_win  = lsq_ok && !if_win;

    mem.command = BUS_NONE;
    mem.addr    = '0;
    mem.wdata   = '0;
    if (if_win) begin
      mem.command = BUS_LOAD;
      mem.addr    = if_addr;
    end else if (lsq_win) begin
      mem.command = bus_cmd_e'(lsq_req);
      mem.addr    = lsq_addr;
      mem.wdata   = lsq_data;
    end

    lsq_grant     = lsq_win && (mem.response != '0);
    if_grant      = if_win && (mem.response != '0);
    lsq_grant_tag = lsq_grant ? mem.response : '0;
    if_grant_tag  = if_grant ? mem.response : '0;

    set_en    = (lsq_grant && lsq_load) || if_grant;
    set_owner = if_grant ? OWNER_IF : OWNER_LSQ;
    set_stale = if_grant && if_flush;

    ret_hit    = reset && (mem.tag != '0) && ret_entry.valid;
    deliver    = ret_hit && !ret_entry.stale;
    lsq_rvalid = deliver && (ret_entry.owner == OWNER_LSQ);
    if_rvalid  = deliver && (ret_entry.owner == OWNER_IF);
    lsq_rtag   = lsq_rvalid ? mem.tag : '0;
    lsq_rdata  = lsq_rvalid ? mem.data : '0;
    if_rtag    = if_rvalid ? mem.tag : '0;
    if_rdata   = if_rvalid ? mem.data : '0;

    starve_d = '0;
    if (if_req && !if_grant) starve_d = if_first ? starve_q : starve_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) starve_q <= '0;
    else        starve_q <= starve_d;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Random and directed checks of mem_bus_arbiter against a tag-ownership model.
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

  localparam int NT = NUM_MEM_TAGS;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  lsq_req;
  logic [63:0] lsq_addr, lsq_data, if_addr;
  logic        if_req, if_flush;
  logic        lsq_grant, lsq_rvalid, if_grant, if_rvalid;
  logic [3:0]  lsq_grant_tag, lsq_rtag, if_grant_tag, if_rtag, outstanding;
  logic [63:0] lsq_rdata, if_rdata;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .lsq_req       (lsq_req),
    .lsq_addr      (lsq_addr),
    .lsq_data      (lsq_data),
    .if_req        (if_req),
    .if_addr       (if_addr),
    .if_flush      (if_flush),
    .mem           (bus),
    .lsq_grant     (lsq_grant),
    .lsq_grant_tag (lsq_grant_tag),
    .lsq_rvalid    (lsq_rvalid),
    .lsq_rtag      (lsq_rtag),
    .lsq_rdata     (lsq_rdata),
    .if_grant      (if_grant),
    .if_grant_tag  (if_grant_tag),
    .if_rvalid     (if_rvalid),
    .if_rtag       (if_rtag),
    .if_rdata      (if_rdata),
    .outstanding   (outstanding)
  );

  always #5 clk = ~clk;

  // Model: per-tag ownership record and the fetch wait streak.
  bit m_valid [0:NT];
  bit m_fetch [0:NT];
  bit m_stale [0:NT];
  int m_starve;

  int checks = 0;
  int failures = 0;

  logic        obs_lg, obs_ig, obs_lrv, obs_irv;
  logic [3:0]  obs_lgt, obs_igt, obs_out;
  logic [1:0]  obs_cmd;
  logic [63:0] obs_lrd, obs_ird;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic int countValid();
    int n = 0;
    for (int t = 1; t <= NT; t++) n += int'(m_valid[t]);
    return n;
  endfunction

  task automatic modelReset();
    for (int t = 0; t <= NT; t++) begin
      m_valid[t] = 0;
      m_fetch[t] = 0;
      m_stale[t] = 0;
    end
    m_starve = 0;
  endtask

  // Called just after a rising edge; checks mid-cycle, then advances the model.
  task automatic applyStimulus(input logic [1:0] lreq, input logic [63:0] laddr, input logic [63:0] ldata,
                               input logic ireq, input logic [63:0] iaddr, input logic flush,
                               input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
    int          winner;
    bit          full, lsq_can, if_can, e_lg, e_ig, live, e_lrv, e_irv;
    logic [1:0]  e_cmd;
    logic [63:0] e_addr, e_wdata;
    lsq_req = lreq; lsq_addr = laddr; lsq_data = ldata;
    if_req = ireq; if_addr = iaddr; if_flush = flush;
    bus.response = resp; bus.tag = rtag; bus.data = rdata;
    #4;
    full    = (countValid() == NT);
    lsq_can = (lreq == 2'b10) || (lreq == 2'b01 && !full);
    if_can  = ireq && !full;
    winner  = 0;
    if (if_can && (m_starve == DEF_STARVE_LIMIT || !lsq_can)) winner = 2;
    else if (lsq_can) winner = 1;
    e_cmd   = (winner == 2) ? 2'b01 : (winner == 1) ? lreq : 2'b00;
    e_addr  = (winner == 2) ? iaddr : (winner == 1) ? laddr : 64'd0;
    e_wdata = (winner == 1) ? ldata : 64'd0;
    e_lg    = (winner == 1) && (resp != 0);
    e_ig    = (winner == 2) && (resp != 0);
    live    = (rtag != 0) && m_valid[rtag] && !m_stale[rtag];
    e_lrv   = live && !m_fetch[rtag];
    e_irv   = live && m_fetch[rtag];

    checkOutput("mem_command", 64'(bus.command), 64'(e_cmd));
    checkOutput("mem_addr", bus.addr, e_addr);
    checkOutput("mem_wdata", bus.wdata, e_wdata);
    checkOutput("lsq_grant", 64'(lsq_grant), 64'(e_lg));
    checkOutput("lsq_grant_tag", 64'(lsq_grant_tag), e_lg ? 64'(resp) : 64'd0);
    checkOutput("if_grant", 64'(if_grant), 64'(e_ig));
    checkOutput("if_grant_tag", 64'(if_grant_tag), e_ig ? 64'(resp) : 64'd0);
    checkOutput("lsq_rvalid", 64'(lsq_rvalid), 64'(e_lrv));
    checkOutput("lsq_rtag", 64'(lsq_rtag), e_lrv ? 64'(rtag) : 64'd0);
    checkOutput("lsq_rdata", lsq_rdata, e_lrv ? rdata : 64'd0);
    checkOutput("if_rvalid", 64'(if_rvalid), 64'(e_irv));
    checkOutput("if_rtag", 64'(if_rtag), e_irv ? 64'(rtag) : 64'd0);
    checkOutput("if_rdata", if_rdata, e_irv ? rdata : 64'd0);
    checkOutput("outstanding", 64'(outstanding), 64'(countValid()));

    obs_cmd = bus.command; obs_lg = lsq_grant; obs_lgt = lsq_grant_tag;
    obs_ig = if_grant; obs_igt = if_grant_tag; obs_lrv = lsq_rvalid; obs_lrd = lsq_rdata;
    obs_irv = if_rvalid; obs_ird = if_rdata; obs_out = outstanding;

    @(posedge clk);
    if (rtag != 0) m_valid[rtag] = 0;
    if (flush) begin
      for (int t = 1; t <= NT; t++) if (m_valid[t] && m_fetch[t]) m_stale[t] = 1;
    end
    if ((e_lg && lreq == 2'b01) || e_ig) begin
      m_valid[resp] = 1;
      m_fetch[resp] = e_ig;
      m_stale[resp] = e_ig && flush;
    end
    if (ireq && !e_ig) m_starve = (m_starve < DEF_STARVE_LIMIT) ? m_starve + 1 : m_starve;
    else m_starve = 0;
    #1;
  endtask

  task automatic idleCycle();
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0, 4'd0, 64'd0);
  endtask

  task automatic drainAll();
    for (int t = 1; t <= NT; t++) begin
      if (m_valid[t]) applyStimulus(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0, 4'(t), {$urandom, $urandom});
    end
  endtask

  initial begin
    logic [1:0]  cur_lreq;
    logic [63:0] cur_laddr, cur_ldata, cur_iaddr;
    logic        cur_ireq, lsq_busy, if_busy, flush;
    logic [3:0]  resp, rtag;
    int          free_tags[$];
    int          busy_tags[$];
    int          r;

    modelReset();
    reset = 1'b0;
    lsq_req = 2'b01; lsq_addr = 64'h40; lsq_data = 64'd0;
    if_req = 1'b1; if_addr = 64'h80; if_flush = 1'b0;
    bus.response = 4'd3; bus.tag = 4'd3; bus.data = 64'h1234;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_command", 64'(bus.command), 64'(BUS_NONE));
    checkOutput("reset_lsq_grant", 64'(lsq_grant), 64'd0);
    checkOutput("reset_if_grant", 64'(if_grant), 64'd0);
    checkOutput("reset_lsq_rvalid", 64'(lsq_rvalid), 64'd0);
    checkOutput("reset_outstanding", 64'(outstanding), 64'd0);
    reset = 1'b1;

    // Basic LSQ load and data return.
    applyStimulus(2'b01, 64'h100, 64'd0, 1'b0, 64'd0, 1'b0, 4'd3, 4'd0, 64'd0);
    checkOutput("tp1_grant", 64'(obs_lg), 64'd1);
    checkOutput("tp1_grant_tag", 64'(obs_lgt), 64'd3);
    idleCycle();
    checkOutput("tp1_outstanding", 64'(obs_out), 64'd1);
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0, 4'd3, 64'hDEAD);
    checkOutput("tp1_rvalid", 64'(obs_lrv), 64'd1);
    checkOutput("tp1_rdata", obs_lrd, 64'hDEAD);
    checkOutput("tp1_if_rvalid", 64'(obs_irv), 64'd0);
    idleCycle();
    checkOutput("tp1_outstanding_zero", 64'(obs_out), 64'd0);

    // Starvation: four LSQ wins, then fetch, then LSQ again.
    for (int c = 0; c < 6; c++) begin
      applyStimulus(2'b01, 64'h200 + 64'(c), 64'd0, 1'b1, 64'h3000, 1'b0, 4'(c + 1), 4'd0, 64'd0);
      checkOutput($sformatf("tp2_lsq_grant_%0d", c), 64'(obs_lg), (c == 4) ? 64'd0 : 64'd1);
      checkOutput($sformatf("tp2_if_grant_%0d", c), 64'(obs_ig), (c == 4) ? 64'd1 : 64'd0);
    end
    drainAll();

    // Flushed fetch load returns silently.
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b1, 64'h4000, 1'b0, 4'd5, 4'd0, 64'd0);
    checkOutput("tp3_if_grant_tag", 64'(obs_igt), 64'd5);
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b1, 4'd0, 4'd0, 64'd0);
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0, 4'd5, 64'hCAFE);
    checkOutput("tp3_if_rvalid", 64'(obs_irv), 64'd0);
    idleCycle();
    checkOutput("tp3_outstanding", 64'(obs_out), 64'd0);

    // Rejections: request held until a nonzero response.
    for (int c = 0; c < 3; c++) begin
      applyStimulus(2'b01, 64'h500, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0, 4'd0, 64'd0);
      checkOutput("tp4_reject_grant", 64'(obs_lg), 64'd0);
      checkOutput("tp4_reject_cmd", 64'(obs_cmd), 64'(BUS_LOAD));
    end
    applyStimulus(2'b01, 64'h500, 64'd0, 1'b0, 64'd0, 1'b0, 4'd2, 4'd0, 64'd0);
    checkOutput("tp4_grant", 64'(obs_lg), 64'd1);
    checkOutput("tp4_grant_tag", 64'(obs_lgt), 64'd2);
    drainAll();

    // Fill every tag; loads stall, stores still issue.
    for (int t = 1; t <= NT; t++) begin
      applyStimulus(2'b01, 64'h600 + 64'(t), 64'd0, 1'b0, 64'd0, 1'b0, 4'(t), 4'd0, 64'd0);
    end
    applyStimulus(2'b01, 64'h700, 64'd0, 1'b1, 64'h800, 1'b0, 4'd1, 4'd0, 64'd0);
    checkOutput("tp5_outstanding", 64'(obs_out), 64'd15);
    checkOutput("tp5_full_cmd", 64'(obs_cmd), 64'(BUS_NONE));
    applyStimulus(2'b10, 64'h700, 64'h99, 1'b0, 64'd0, 1'b0, 4'd1, 4'd0, 64'd0);
    checkOutput("tp5_store_cmd", 64'(obs_cmd), 64'(BUS_STORE));
    checkOutput("tp5_store_grant", 64'(obs_lg), 64'd1);
    drainAll();

    // Tag 7 returns to the LSQ while being reissued to fetch.
    applyStimulus(2'b01, 64'h900, 64'd0, 1'b0, 64'd0, 1'b0, 4'd7, 4'd0, 64'd0);
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b1, 64'hA00, 1'b0, 4'd7, 4'd7, 64'hBEEF);
    checkOutput("tp6_lsq_rdata", obs_lrd, 64'hBEEF);
    checkOutput("tp6_if_grant_tag", 64'(obs_igt), 64'd7);
    idleCycle();
    checkOutput("tp6_outstanding", 64'(obs_out), 64'd1);
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0, 4'd7, 64'hF00D);
    checkOutput("tp6_if_rvalid", 64'(obs_irv), 64'd1);

    // Randomized traffic with requesters holding until granted.
    lsq_busy = 0; if_busy = 0;
    cur_lreq = 2'b00; cur_ireq = 0; cur_laddr = 0; cur_ldata = 0; cur_iaddr = 0;
    for (int n = 0; n < 400; n++) begin
      if (!lsq_busy) begin
        r = $urandom_range(0, 9);
        cur_lreq  = (r < 4) ? 2'b00 : (r < 7) ? 2'b01 : 2'b10;
        cur_laddr = {$urandom, $urandom};
        cur_ldata = {$urandom, $urandom};
        lsq_busy  = (cur_lreq != 2'b00);
      end
      if (!if_busy) begin
        cur_ireq  = ($urandom_range(0, 2) == 0);
        cur_iaddr = {$urandom, $urandom};
        if_busy   = cur_ireq;
      end
      free_tags.delete();
      busy_tags.delete();
      for (int t = 1; t <= NT; t++) begin
        if (m_valid[t]) busy_tags.push_back(t);
        else free_tags.push_back(t);
      end
      r = $urandom_range(0, 9);
      if (r < 5 && busy_tags.size() > 0) rtag = 4'(busy_tags[$urandom_range(0, busy_tags.size() - 1)]);
      else if (r == 5) rtag = 4'($urandom_range(1, NT));
      else rtag = 4'd0;
      r = $urandom_range(0, 9);
      if (r < 2) resp = 4'd0;
      else if (r == 2 && rtag != 0 && m_valid[rtag]) resp = rtag;
      else if (free_tags.size() > 0) resp = 4'(free_tags[$urandom_range(0, free_tags.size() - 1)]);
      else resp = 4'd0;
      flush = ($urandom_range(0, 11) == 0);
      applyStimulus(cur_lreq, cur_laddr, cur_ldata, cur_ireq, cur_iaddr, flush, resp, rtag, {$urandom, $urandom});
      if (obs_lg) lsq_busy = 0;
      if (obs_ig) if_busy = 0;
    end
    drainAll();

    // Reset with four tags in flight.
    for (int t = 1; t <= 4; t++) begin
      applyStimulus(2'b01, 64'hB00, 64'd0, 1'b0, 64'd0, 1'b0, 4'(t), 4'd0, 64'd0);
    end
    lsq_req = 2'b01; if_req = 1'b1; bus.response = 4'd6; bus.tag = 4'd2; bus.data = 64'h77;
    #2;
    reset = 1'b0;
    #1;
    checkOutput("tp7_command", 64'(bus.command), 64'(BUS_NONE));
    checkOutput("tp7_addr", bus.addr, 64'd0);
    checkOutput("tp7_lsq_grant", 64'(lsq_grant), 64'd0);
    checkOutput("tp7_if_grant", 64'(if_grant), 64'd0);
    checkOutput("tp7_lsq_rvalid", 64'(lsq_rvalid), 64'd0);
    checkOutput("tp7_lsq_rdata", lsq_rdata, 64'd0);
    checkOutput("tp7_outstanding", 64'(outstanding), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    modelReset();
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0, 4'd2, 64'h55);
    checkOutput("tp7_late_rvalid", 64'(obs_lrv), 64'd0);
    applyStimulus(2'b00, 64'd0, 64'd0, 1'b0, 64'd0, 1'b0, 4'd0, 4'd3, 64'h66);
    checkOutput("tp7_late_rvalid2", 64'(obs_lrv), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
